// File: rtl/acu_write_ctrl.sv
// Write-side execution controller for the accumulator. It accepts ALU ops over valid/ready,
// combines each operand with the accumulator readback, and drives the accumulator write and the zero/carry flags.
module acu_write_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] acu_q,
  output logic [WIDTH-1:0] acu_d,
  output logic             ce_acu,
  output logic             flag_z,
  output logic             flag_c,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;
  typedef enum logic [2:0] {
    OP_NOP, OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL
  } op_t;

  state_t           state;
  op_t              op;
  logic [WIDTH-1:0] sreg;
  logic [SW-1:0]    cnt;
  logic             carry_tmp;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SW-1:0]    shamt;
  logic             accept;

  assign op       = op_t'(opcode);
  assign op_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);
  assign accept   = op_valid && op_ready;
  assign shamt    = operand[SW-1:0];
  assign sum      = {1'b0, acu_q} + {1'b0, operand};
  // The extra top bit of the difference is the borrow (set iff operand > acu_q).
  assign diff     = {1'b0, acu_q} - {1'b0, operand};

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    alu_res = operand;
    alu_c   = 1'b0;
    case (op)
      OP_ADD: begin alu_res = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
      OP_SUB: begin alu_res = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
      OP_AND: alu_res = acu_q & operand;
      OP_OR:  alu_res = acu_q | operand;
      OP_XOR: alu_res = acu_q ^ operand;
      default: alu_res = operand;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acu_d     <= '0;
      ce_acu    <= 1'b0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      sreg      <= '0;
      cnt       <= '0;
      carry_tmp <= 1'b0;
    end else begin
      ce_acu <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op == OP_SHL) begin
              sreg      <= acu_q;
              cnt       <= shamt;
              carry_tmp <= 1'b0;
              if (shamt == '0) begin
                acu_d  <= acu_q;
                ce_acu <= 1'b1;
                state  <= WRITE;
              end else begin
                state <= SHIFT;
              end
            end else if (op != OP_NOP) begin
              acu_d     <= alu_res;
              carry_tmp <= alu_c;
              ce_acu    <= 1'b1;
              state     <= WRITE;
            end
          end
        end
        SHIFT: begin
          carry_tmp <= sreg[WIDTH-1];
          sreg      <= {sreg[WIDTH-2:0], 1'b0};
          cnt       <= cnt - SW'(1);
          // The last shift lands its result straight in acu_d so the write follows immediately.
          if (cnt == SW'(1)) begin
            acu_d  <= {sreg[WIDTH-2:0], 1'b0};
            ce_acu <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          flag_z <= (acu_d == '0);
          flag_c <= carry_tmp;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acu_write_ctrl.sv
// Self-checking bench for acu_write_ctrl. A behavioural accumulator feeds acu_q.
// A scoreboard queue holds the expected write results.
module tb_acu_write_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] opcode;
  logic [7:0] operand;
  logic [7:0] acu_q;
  logic [7:0] acu_d;
  logic       ce_acu;
  logic       flag_z;
  logic       flag_c;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic       z;
    logic       c;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [7:0] acc = 8'h00;
  logic       flag_pend = 1'b0;
  exp_t       last_exp;

  acu_write_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .opcode(opcode), .operand(operand), .acu_q(acu_q), .acu_d(acu_d),
    .ce_acu(ce_acu), .flag_z(flag_z), .flag_c(flag_c), .busy(busy)
  );

  always #5 clk = ~clk;

  // The behavioural accumulator takes acu_d on each write enable.
  always @(posedge clk) if (ce_acu) acc <= acu_d;
  assign acu_q = acc;

  // Each write is popped from the scoreboard. The flags are checked the following cycle.
  always @(negedge clk) begin
    if (flag_pend) begin
      n_cmp++;
      if (flag_z !== last_exp.z || flag_c !== last_exp.c) begin
        n_mis++;
        $display("FAIL flags_after_write: got z=%b c=%b expected z=%b c=%b",
                 flag_z, flag_c, last_exp.z, last_exp.c);
      end
    end
    flag_pend = 1'b0;
    if (ce_acu === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_write: acu_d=%h with empty scoreboard", acu_d);
      end else begin
        last_exp = sb.pop_front();
        if (acu_d !== last_exp.data) begin
          n_mis++;
          $display("FAIL write_data: got %h expected %h", acu_d, last_exp.data);
        end
        flag_pend = 1'b1;
      end
    end
  end

  function automatic exp_t model(input logic [2:0] opc, input logic [7:0] opd, input logic [7:0] a);
    exp_t e;
    int s;
    logic [7:0] v;
    e.c = 1'b0;
    case (opc)
      3'd1: v = opd;
      3'd2: begin s = int'(a) + int'(opd); v = s[7:0]; e.c = (s > 255); end
      3'd3: begin v = a - opd; e.c = (opd > a); end
      3'd4: v = a & opd;
      3'd5: v = a | opd;
      3'd6: v = a ^ opd;
      3'd7: begin
        v = a;
        for (int i = 0; i < int'(opd[2:0]); i++) begin
          e.c = v[7];
          v   = {v[6:0], 1'b0};
        end
      end
      default: v = a;
    endcase
    e.data = v;
    e.z    = (v == 8'h00);
    return e;
  endfunction

  // This task is entered #1 after an edge with op_ready high. It returns #1 after the edge that follows the write.
  task automatic run_op(input logic [2:0] opc, input logic [7:0] opd, output int lat, output int nbusy);
    sb.push_back(model(opc, opd, acc));
    op_valid = 1'b1;
    opcode   = opc;
    operand  = opd;
    @(posedge clk); #1;
    op_valid = 1'b0;
    lat   = 1;
    nbusy = int'(busy);
    while (ce_acu !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      nbusy += int'(busy);
    end
    @(posedge clk); #1;
    nbusy += int'(busy);
  endtask

  task automatic test_reset_por();
    rst = 1'b1; op_valid = 1'b0; opcode = 3'd0; operand = 8'h00;
    #1;
    n_cmp++;
    if (op_ready !== 1'b0) begin n_mis++; $display("FAIL por_ready_in_rst: got %b expected 0", op_ready); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({acu_d, ce_acu, flag_z, flag_c, busy} !== 12'h000) begin
      n_mis++;
      $display("FAIL por_state: acu_d=%h ce=%b z=%b c=%b busy=%b expected all zero",
               acu_d, ce_acu, flag_z, flag_c, busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (op_ready !== 1'b1) begin n_mis++; $display("FAIL por_ready_after: got %b expected 1", op_ready); end
  endtask

  task automatic test_load_add();
    int lat, nb;
    run_op(3'd1, 8'h3C, lat, nb);
    n_cmp++;
    if (lat !== 1) begin n_mis++; $display("FAIL load_latency: got %0d expected 1", lat); end
    n_cmp++;
    if (op_ready !== 1'b1) begin n_mis++; $display("FAIL load_ready_gap: got %b expected 1", op_ready); end
    run_op(3'd2, 8'hD0, lat, nb);
    n_cmp++;
    if (lat !== 1) begin n_mis++; $display("FAIL add_latency: got %0d expected 1", lat); end
    n_cmp++;
    if ({acu_d, flag_z, flag_c} !== {8'h0C, 1'b0, 1'b1}) begin
      n_mis++;
      $display("FAIL add_result: got d=%h z=%b c=%b expected d=0c z=0 c=1", acu_d, flag_z, flag_c);
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    #1;
    n_cmp++;
    if (op_ready !== 1'b0) begin n_mis++; $display("FAIL mid_ready_in_rst: got %b expected 0", op_ready); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({acu_d, ce_acu, flag_z, flag_c} !== 11'h000) begin
      n_mis++;
      $display("FAIL mid_reset_state: acu_d=%h ce=%b z=%b c=%b expected all zero", acu_d, ce_acu, flag_z, flag_c);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (op_ready !== 1'b1) begin n_mis++; $display("FAIL mid_ready_after: got %b expected 1", op_ready); end
  endtask

  task automatic test_sub();
    int lat, nb;
    run_op(3'd3, 8'h0C, lat, nb);
    n_cmp++;
    if ({acu_d, flag_z, flag_c} !== {8'h00, 1'b1, 1'b0}) begin
      n_mis++;
      $display("FAIL sub_zero: got d=%h z=%b c=%b expected d=00 z=1 c=0", acu_d, flag_z, flag_c);
    end
    run_op(3'd3, 8'h01, lat, nb);
    n_cmp++;
    if ({acu_d, flag_z, flag_c} !== {8'hFF, 1'b0, 1'b1}) begin
      n_mis++;
      $display("FAIL sub_borrow: got d=%h z=%b c=%b expected d=ff z=0 c=1", acu_d, flag_z, flag_c);
    end
  endtask

  task automatic test_shl();
    int lat, nb;
    run_op(3'd1, 8'hB1, lat, nb);
    run_op(3'd7, 8'h03, lat, nb);
    n_cmp++;
    if (lat !== 4 || nb !== 4) begin
      n_mis++;
      $display("FAIL shl3_timing: got latency %0d busy %0d expected 4 and 4", lat, nb);
    end
    n_cmp++;
    if ({acu_d, flag_c} !== {8'h88, 1'b1}) begin
      n_mis++;
      $display("FAIL shl3_result: got d=%h c=%b expected d=88 c=1", acu_d, flag_c);
    end
    run_op(3'd7, 8'h00, lat, nb);
    n_cmp++;
    if (lat !== 1) begin n_mis++; $display("FAIL shl0_latency: got %0d expected 1", lat); end
    n_cmp++;
    if ({acu_d, flag_c} !== {8'h88, 1'b0}) begin
      n_mis++;
      $display("FAIL shl0_result: got d=%h c=%b expected d=88 c=0", acu_d, flag_c);
    end
  endtask

  task automatic test_shl_abort();
    int lat, nb, nce;
    run_op(3'd1, 8'h01, lat, nb);
    op_valid = 1'b1; opcode = 3'd7; operand = 8'h07;
    @(posedge clk); #1;
    op_valid = 1'b0;
    nce = int'(ce_acu);
    @(posedge clk); #1;
    nce += int'(ce_acu);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({acu_d, ce_acu, flag_z, flag_c, busy, op_ready} !== 13'h0000) begin
      n_mis++;
      $display("FAIL abort_reset_state: acu_d=%h ce=%b z=%b c=%b busy=%b rdy=%b expected all zero",
               acu_d, ce_acu, flag_z, flag_c, busy, op_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (op_ready !== 1'b1) begin n_mis++; $display("FAIL abort_ready_after: got %b expected 1", op_ready); end
    for (int i = 0; i < 10; i++) begin
      nce += int'(ce_acu);
      @(posedge clk); #1;
    end
    n_cmp++;
    if (nce !== 0) begin n_mis++; $display("FAIL abort_no_write: got %0d pulses expected 0", nce); end
  endtask

  task automatic test_back_to_back();
    int lat, nb;
    logic z0, c0;
    logic [2:0] ops [3];
    logic [7:0] opds [3];
    logic [7:0] want [3];
    ops  = '{3'd4, 3'd5, 3'd6};
    opds = '{8'h0F, 8'hF0, 8'hFF};
    want = '{8'h0A, 8'hFA, 8'h05};
    run_op(3'd1, 8'h5A, lat, nb);
    z0 = flag_z; c0 = flag_c;
    op_valid = 1'b1; opcode = 3'd0; operand = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (op_ready !== 1'b1 || ce_acu !== 1'b0 || flag_z !== z0 || flag_c !== c0) begin
        n_mis++;
        $display("FAIL nop_hold: cycle %0d rdy=%b ce=%b z=%b c=%b", i, op_ready, ce_acu, flag_z, flag_c);
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (op_ready !== 1'b1 || ce_acu !== 1'b0) begin
        n_mis++;
        $display("FAIL b2b_ready_%0d: rdy=%b ce=%b expected 1 0", k, op_ready, ce_acu);
      end
      sb.push_back(model(ops[k], opds[k], acc));
      opcode = ops[k]; operand = opds[k];
      @(posedge clk); #1;
      n_cmp++;
      if (ce_acu !== 1'b1 || op_ready !== 1'b0 || acu_d !== want[k]) begin
        n_mis++;
        $display("FAIL b2b_write_%0d: ce=%b rdy=%b d=%h expected 1 0 %h", k, ce_acu, op_ready, acu_d, want[k]);
      end
      @(posedge clk); #1;
    end
    op_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (ce_acu !== 1'b0 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL b2b_no_duplicate: ce=%b busy=%b expected 0 0", ce_acu, busy);
    end
  endtask

  initial begin
    test_reset_por();
    test_load_add();
    test_reset_mid();
    test_sub();
    test_shl();
    test_shl_abort();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() !== 0) begin n_mis++; $display("FAIL scoreboard_drain: %0d writes missing", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/acu_write_ctrl.md
# acu_write_ctrl

Execution controller on the write side of the accumulator register. It accepts ALU operations over a valid/ready handshake and combines each operand with the current accumulator readback. It then drives the accumulator's data input and one-cycle write enable, and maintains zero/carry flags. Sits between instruction decode and the accumulator; the accumulator itself is unchanged.

## Interface
- WIDTH, 8, data width; power of two, ≥4
- clk  input  1  clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- op_valid  input  1  operation request
- op_ready  output  1  controller can accept an operation
- opcode  input  3  0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 SHL
- operand  input  WIDTH  operand; for SHL, low $clog2(WIDTH) bits = shift amount n
- acu_q  input  WIDTH  accumulator readback (registered output of accumulator)
- acu_d  output  WIDTH  value to write into accumulator, registered
- ce_acu  output  1  accumulator write enable, registered, one-cycle pulse per write
- flag_z  output  1  result of last write was zero
- flag_c  output  1  carry/borrow/last shifted-out bit of last write
- busy  output  1  operation in progress (state ≠ IDLE)

## Operation
- States: IDLE, SHIFT, WRITE.
- op_ready = (state == IDLE) && !rst. Accept when op_valid && op_ready.
- NOP accepted: stays IDLE, no ce_acu, flags unchanged.
- LOAD/ADD/SUB/AND/OR/XOR accepted at edge T: result computed from acu_q and operand sampled in T, registered into acu_d; state → WRITE.
  - LOAD: operand; carry 0.
  - ADD: WIDTH+1-bit sum; acu_d = low WIDTH bits, carry = bit WIDTH.
  - SUB: acu_q − operand mod 2^WIDTH; carry = 1 iff operand > acu_q (borrow).
  - AND/OR/XOR: bitwise; carry 0.
- SHL accepted: working register ← acu_q, counter ← n, carry_tmp ← 0.
  - n = 0: state → WRITE with acu_d = acu_q, carry 0.
  - Otherwise state → SHIFT. Each SHIFT cycle: carry_tmp ← MSB, register << 1 (LSB 0), counter −1. At counter = 1, shift and go to WRITE.
- WRITE (one cycle): ce_acu = 1, acu_d = result; flag_z ← (result == 0), flag_c ← carry, both registered so they are visible the cycle after WRITE. State → IDLE.
- acu_d holds last value when ce_acu = 0.
- opcode/operand ignored unless accepted.

## Timing
- Reset: state IDLE, acu_d = 0, ce_acu = 0, flag_z = 0, flag_c = 0, busy = 0, counter = 0, op_ready = 0 while rst high.
- Non-shift op accepted at T: ce_acu high in cycle T+1. op_ready low in T+1, high in T+2.
- Next op accepted no earlier than T+2, when acu_q already reflects the T+1 write. Maximum throughput is one write per 2 cycles.
- SHL by n accepted at T: SHIFT cycles T+1..T+n, ce_acu at T+n+1, op_ready high at T+n+2. For n = 0, ce_acu at T+1.
- rst asserted in any state: at the next edge, all state and outputs take reset values. Pending results are discarded, with no ce_acu pulse.
- op_valid held high continuously: one op is accepted per ready window, with no duplicates or drops.

## Test plan
Bench: WIDTH=8, with a behavioural accumulator model feeding acu_q.
- Reset: rst high 2 cycles mid-stream → acu_d=0x00, ce_acu=0, flag_z=0, flag_c=0, op_ready=0. Deassert → op_ready=1 next cycle.
- LOAD 0x3C then ADD 0xD0 → ce_acu one cycle after each accept. Second write is acu_d=0x0C, flag_c=1, flag_z=0. Gaps between accepts are exactly 2 cycles.
- With acc=0x0C: SUB 0x0C → 0x00, flag_z=1, flag_c=0. Then SUB 0x01 → 0xFF, flag_c=1, flag_z=0.
- With acc=0xB1: SHL 3 → busy 4 cycles, ce_acu at accept+4, acu_d=0x88, flag_c=1. SHL 0 → ce_acu at accept+1, acu_d=acc, flag_c=0.
- With acc=0x01: SHL 7 accepted at T, rst pulsed at T+3 → no ce_acu, all outputs at reset values, op_ready=1 after release.
- op_valid held high with NOP → op_ready stays 1, no ce_acu, flags unchanged. Switch to AND 0x0F, OR 0xF0, XOR 0xFF from acc=0x5A → writes 0x0A, 0xFA, 0x05, spaced 2 cycles apart.
